// File: rtl/dshade_seq.sv
// Gouraud interpolation sequencer: NCH lane accumulators in IW.FW fixed point.
// Each accepted write emits the lane integers, then steps fraction and integer on two ticks.
module dshade_lane #(
  parameter int IW = 8,
  parameter int FW = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             acc_ld_i,
  input  logic             inc_ld_i,
  input  logic [IW+FW-1:0] acc_din_i,
  input  logic [IW+FW-1:0] inc_din_i,
  input  logic             step_frac_i,
  input  logic             step_int_i,
  input  logic             clamp_en_i,
  output logic [IW-1:0]    int_o
);
  localparam int W = IW + FW;

  logic [IW-1:0] int_q, int_d;
  logic [FW-1:0] frac_q, frac_d;
  logic [W-1:0]  inc_q, inc_d;
  logic          carry_q, carry_d;
  logic [FW:0]   fsum;
  logic [IW:0]   isum;
  logic          inc_neg;

  assign inc_neg = inc_q[W-1];
  assign fsum    = {1'b0, frac_q} + {1'b0, inc_q[FW-1:0]};
  // int + sign-extended increment + carry; bit IW flags out-of-range for either sign
  assign isum    = {1'b0, int_q} + {inc_neg, inc_q[W-1:FW]} + {{IW{1'b0}}, carry_q};
  assign int_o   = int_q;

  always_comb begin
    int_d   = int_q;
    frac_d  = frac_q;
    carry_d = carry_q;
    inc_d   = inc_ld_i ? inc_din_i : inc_q;
    if (acc_ld_i) begin
      int_d  = acc_din_i[W-1:FW];
      frac_d = acc_din_i[FW-1:0];
    end else if (step_frac_i) begin
      frac_d  = fsum[FW-1:0];
      carry_d = fsum[FW];
    end else if (step_int_i) begin
      if (clamp_en_i && isum[IW] && !inc_neg) begin
        int_d  = {IW{1'b1}};
        frac_d = {FW{1'b1}};
      end else if (clamp_en_i && isum[IW] && inc_neg) begin
        int_d  = '0;
        frac_d = '0;
      end else begin
        int_d = isum[IW-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      int_q   <= '0;
      frac_q  <= '0;
      inc_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      int_q   <= int_d;
      frac_q  <= frac_d;
      inc_q   <= inc_d;
      carry_q <= carry_d;
    end
  end
endmodule

module dshade_seq #(
  parameter int NCH = 4,
  parameter int IW  = 8,
  parameter int FW  = 16
) (
  input  logic                  sys_clk,
  input  logic                  reset,
  input  logic                  cmd_ld,
  input  logic [1:0]            cmd_din,
  input  logic                  acc_ld,
  input  logic [NCH*(IW+FW)-1:0] acc_din,
  input  logic                  inc_ld,
  input  logic [NCH*(IW+FW)-1:0] inc_din,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic                  pix_valid,
  output logic [NCH*IW-1:0]     pix_data,
  output logic                  busy
);
  localparam int W = IW + FW;

  typedef enum logic [1:0] {S_IDLE, S_FRAC, S_INT} state_t;

  state_t              state_q, state_d;
  logic [1:0]          mode_q;
  logic                pix_valid_q;
  logic [NCH*IW-1:0]   pix_data_q;
  logic [NCH*IW-1:0]   lane_int;
  logic                accept, step_frac, step_int;

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // acc_ld overrides everything: a coincident accept or an in-flight step goes back to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && mode_q[0] && !acc_ld) state_d = S_FRAC;
      S_FRAC:  state_d = acc_ld ? S_IDLE : S_INT;
      S_INT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ready  = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    step_frac = (state_q == S_FRAC);
    step_int  = (state_q == S_INT);
    accept    = wr_valid && (state_q == S_IDLE);
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      mode_q      <= '0;
      pix_valid_q <= 1'b0;
      pix_data_q  <= '0;
    end else begin
      if (cmd_ld) mode_q <= cmd_din;
      pix_valid_q <= accept;
      if (accept) pix_data_q <= lane_int;
    end
  end

  assign pix_valid = pix_valid_q;
  assign pix_data  = pix_data_q;

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    dshade_lane #(.IW(IW), .FW(FW)) u_lane (
      .clk_i       (sys_clk),
      .rst_i       (reset),
      .acc_ld_i    (acc_ld),
      .inc_ld_i    (inc_ld),
      .acc_din_i   (acc_din[k*W +: W]),
      .inc_din_i   (inc_din[k*W +: W]),
      .step_frac_i (step_frac),
      .step_int_i  (step_int),
      .clamp_en_i  (mode_q[1]),
      .int_o       (lane_int[k*IW +: IW])
    );
  end
endmodule

// File: tb/tb_dshade_seq.sv
// Bench for dshade_seq: table rows for single-lane-pattern sequences, hand sequences for
// aborts, resets and per-lane increments; pix outputs checked against a scoreboard queue.
module tb_dshade_seq;
  localparam int NCH = 4;
  localparam int IW  = 8;
  localparam int FW  = 16;
  localparam int W   = IW + FW;
  localparam longint MAXV = (64'd1 << W) - 1;

  logic                 sys_clk = 1'b0;
  logic                 reset;
  logic                 cmd_ld = 1'b0;
  logic [1:0]           cmd_din = '0;
  logic                 acc_ld = 1'b0;
  logic [NCH*W-1:0]     acc_din = '0;
  logic                 inc_ld = 1'b0;
  logic [NCH*W-1:0]     inc_din = '0;
  logic                 wr_valid = 1'b0;
  logic                 wr_ready, pix_valid, busy;
  logic [NCH*IW-1:0]    pix_data;

  dshade_seq #(.NCH(NCH), .IW(IW), .FW(FW)) dut (
    .sys_clk(sys_clk), .reset(reset), .cmd_ld(cmd_ld), .cmd_din(cmd_din),
    .acc_ld(acc_ld), .acc_din(acc_din), .inc_ld(inc_ld), .inc_din(inc_din),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .pix_valid(pix_valid),
    .pix_data(pix_data), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;
  logic [NCH*IW-1:0] sbq[$];

  // bench reference model: whole fixed-point value per lane
  longint m_acc[NCH];
  longint m_inc[NCH];
  logic [1:0] m_mode;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge sys_clk) begin
    if (pix_valid) begin
      if (sbq.size() == 0) chk("unexpected_pix", 64'(pix_data), 64'hdead);
      else chk("pix_data", 64'(pix_data), 64'(sbq.pop_front()));
    end
  end

  function automatic logic [NCH*IW-1:0] rep8(input logic [7:0] v);
    return {NCH{v}};
  endfunction

  function automatic logic [NCH*W-1:0] repw(input logic [W-1:0] v);
    return {NCH{v}};
  endfunction

  function automatic logic [NCH*IW-1:0] mpix();
    logic [NCH*IW-1:0] r;
    for (int k = 0; k < NCH; k++) r[k*IW +: IW] = 8'(m_acc[k] >> FW);
    return r;
  endfunction

  task automatic mstep();
    for (int k = 0; k < NCH; k++) begin
      longint nv = m_acc[k] + m_inc[k];
      if (m_mode[1] && m_inc[k] >= 0 && nv > MAXV) nv = MAXV;
      else if (m_mode[1] && m_inc[k] < 0 && nv < 0) nv = 0;
      else nv = nv & MAXV;
      m_acc[k] = nv;
    end
  endtask

  // drive loads for one cycle from a negedge; DUT is expected to be IDLE
  task automatic ld(input bit la, input bit li, input bit lc,
                    input logic [NCH*W-1:0] a, input logic [NCH*W-1:0] i, input logic [1:0] m);
    @(negedge sys_clk);
    acc_ld = la; inc_ld = li; cmd_ld = lc;
    acc_din = a; inc_din = i; cmd_din = m;
    for (int k = 0; k < NCH; k++) begin
      if (la) m_acc[k] = longint'(a[k*W +: W]);
      if (li) m_inc[k] = longint'($signed(i[k*W +: W]));
    end
    if (lc) m_mode = m;
    @(negedge sys_clk);
    acc_ld = 1'b0; inc_ld = 1'b0; cmd_ld = 1'b0;
  endtask

  // one accepted write; with gour also checks the two busy cycles
  task automatic wr(input logic [NCH*IW-1:0] exp, input bit gour);
    int n = 0;
    @(negedge sys_clk);
    while (!wr_ready && n < 20) begin @(negedge sys_clk); n++; end
    if (!wr_ready) begin chk("wr_ready_timeout", 64'(wr_ready), 64'd1); return; end
    wr_valid = 1'b1;
    sbq.push_back(exp);
    @(negedge sys_clk);
    wr_valid = 1'b0;
    if (gour) begin
      chk("ready_frac", 64'(wr_ready), 64'd0);
      chk("busy_frac", 64'(busy), 64'd1);
      @(negedge sys_clk);
      chk("ready_int", 64'(wr_ready), 64'd0);
      @(negedge sys_clk);
      chk("ready_done", 64'(wr_ready), 64'd1);
    end else begin
      chk("ready_nogour", 64'(wr_ready), 64'd1);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 20) begin @(negedge sys_clk); n++; end
    chk("scoreboard_drain", 64'(sbq.size()), 64'd0);
  endtask

  typedef struct {
    logic [1:0]       mode;
    logic [W-1:0]     acc;
    logic [W-1:0]     inc;
    logic [2:0][7:0]  exp;   // exp[0] first write
  } vec_t;

  vec_t tbl[6];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{2'b01, 24'h10_0000, 24'h01_8000, {8'h13, 8'h11, 8'h10}};
    tbl[1] = '{2'b11, 24'hFE_0000, 24'h02_0000, {8'hFF, 8'hFF, 8'hFE}};
    tbl[2] = '{2'b01, 24'hFE_0000, 24'h02_0000, {8'h02, 8'h00, 8'hFE}};
    tbl[3] = '{2'b11, 24'h01_8000, 24'hFE_0000, {8'h00, 8'h00, 8'h01}};
    tbl[4] = '{2'b00, 24'h10_0000, 24'h01_0000, {8'h10, 8'h10, 8'h10}};
    tbl[5] = '{2'b01, 24'h00_8000, 24'h00_8000, {8'h01, 8'h01, 8'h00}};
    for (int k = 0; k < NCH; k++) begin m_acc[k] = 0; m_inc[k] = 0; end
    m_mode = '0;

    reset = 1'b1;
    @(negedge sys_clk);
    chk("rst_pix_valid", 64'(pix_valid), 64'd0);
    chk("rst_pix_data", 64'(pix_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_wr_ready", 64'(wr_ready), 64'd1);
    reset = 1'b0;

    for (int r = 0; r < 6; r++) begin
      ld(1, 1, 1, repw(tbl[r].acc), repw(tbl[r].inc), tbl[r].mode);
      for (int j = 0; j < 3; j++) wr(rep8(tbl[r].exp[j]), tbl[r].mode[0]);
      drain();
      if (r == 1) begin
        // clamp leaves FF.FFFF: a tiny step without clamp wraps only if frac saturated
        ld(0, 1, 1, '0, repw(24'h00_0001), 2'b01);
        wr(rep8(8'hFF), 1);
        wr(rep8(8'h00), 1);
        drain();
      end
      if (r == 3) begin
        // underflow must also clear the fraction (was .8000)
        ld(0, 1, 1, '0, repw(24'h00_8000), 2'b01);
        wr(rep8(8'h00), 1);
        wr(rep8(8'h00), 1);
        wr(rep8(8'h01), 1);
        drain();
      end
    end

    // back-to-back writes without gouraud
    ld(1, 1, 1, repw(24'h33_0000), repw(24'h01_0000), 2'b00);
    @(negedge sys_clk);
    wr_valid = 1'b1;
    for (int i = 0; i < 4; i++) sbq.push_back(rep8(8'h33));
    for (int i = 0; i < 4; i++) begin
      @(negedge sys_clk);
      chk("b2b_pix_valid", 64'(pix_valid), 64'd1);
      chk("b2b_ready", 64'(wr_ready), 64'd1);
    end
    wr_valid = 1'b0;
    @(negedge sys_clk);
    chk("b2b_end_valid", 64'(pix_valid), 64'd0);
    drain();

    // acc_ld during FRAC aborts the step
    ld(1, 1, 1, repw(24'h10_0000), repw(24'h01_0000), 2'b01);
    @(negedge sys_clk);
    wr_valid = 1'b1;
    sbq.push_back(rep8(8'h10));
    @(negedge sys_clk);
    wr_valid = 1'b0;
    chk("abort_in_frac", 64'(busy), 64'd1);
    acc_ld = 1'b1; acc_din = repw(24'h20_0000);
    @(negedge sys_clk);
    acc_ld = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_ready", 64'(wr_ready), 64'd1);
    @(negedge sys_clk);
    chk("abort_no_int", 64'(busy), 64'd0);
    ld(0, 0, 1, '0, '0, 2'b00);
    wr(rep8(8'h20), 0);
    drain();

    // acc_ld coincident with an accepted write
    ld(1, 0, 1, repw(24'h30_0000), '0, 2'b01);
    @(negedge sys_clk);
    wr_valid = 1'b1; acc_ld = 1'b1; acc_din = repw(24'h40_0000);
    sbq.push_back(rep8(8'h30));
    @(negedge sys_clk);
    wr_valid = 1'b0; acc_ld = 1'b0;
    chk("coinc_ready", 64'(wr_ready), 64'd1);
    chk("coinc_busy", 64'(busy), 64'd0);
    wr(rep8(8'h40), 1);
    wr(rep8(8'h41), 1);
    drain();

    // reset pulsed while in INT
    ld(1, 1, 1, repw(24'h50_0000), repw(24'h01_0000), 2'b11);
    @(negedge sys_clk);
    wr_valid = 1'b1;
    sbq.push_back(rep8(8'h50));
    @(negedge sys_clk);
    wr_valid = 1'b0;
    @(negedge sys_clk);
    chk("pre_rst_int", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    chk("midrst_pix_data", 64'(pix_data), 64'd0);
    chk("midrst_pix_valid", 64'(pix_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_ready", 64'(wr_ready), 64'd1);
    @(negedge sys_clk);
    chk("midrst_ready2", 64'(wr_ready), 64'd1);
    reset = 1'b0;
    for (int k = 0; k < NCH; k++) begin m_acc[k] = 0; m_inc[k] = 0; end
    m_mode = '0;
    wr(rep8(8'h00), 0);
    drain();

    // per-lane increments against the model
    ld(1, 1, 1, repw(24'h80_0000),
       {24'h00_0000, 24'h00_4000, 24'hFF_0000, 24'h01_0000}, 2'b01);
    for (int i = 0; i < 4; i++) begin
      wr(mpix(), 1);
      mstep();
    end
    wr(mpix(), 1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
